// File: rtl/duty_meas_ctrl.sv
// Duty-cycle / period measurement sequencer: syncs sig, gates on rising edges, counts N periods.
// Optional continuous back-to-back windows when DUTY_CONTINUOUS_EN is defined (adds port cont).
module duty_meas_ctrl #(
  parameter int unsigned CW = 32,
  parameter int unsigned NW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_periods,
  input  logic [CW-1:0] timeout_cyc,
  input  logic          sig,
`ifdef DUTY_CONTINUOUS_EN
  input  logic          cont,
`endif
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] out_high,
  output logic [CW-1:0] out_T,
  output logic          timeout_err
);

  typedef enum logic [1:0] {StIdle, StArm, StGate} state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_t_q, cnt_t_d, cnt_h_q, cnt_h_d;
  logic [CW-1:0] wd_q, wd_d, to_q, to_d;
  logic [CW-1:0] out_t_q, out_t_d, out_h_q, out_h_d;
  logic [NW-1:0] per_q, per_d, n_q, n_d;
  logic          valid_q, valid_d, terr_q, terr_d;

  logic          rise, wd_exp, last;
  logic [NW:0]   per_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CW'(1) : v;
  endfunction

  assign rise    = s2_q & ~s3_q;
  assign per_inc = {1'b0, per_q} + (NW+1)'(1);
  assign last    = (per_inc == {1'b0, n_q});
  // A rise in the same cycle always beats watchdog expiry.
  assign wd_exp  = (to_q != '0) && (wd_q == to_q - CW'(1)) && !rise;

  always_comb begin
    state_d = state_q;
    cnt_t_d = cnt_t_q;
    cnt_h_d = cnt_h_q;
    wd_d    = wd_q;
    to_d    = to_q;
    per_d   = per_q;
    n_d     = n_q;
    out_t_d = out_t_q;
    out_h_d = out_h_q;
    valid_d = 1'b0;
    terr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = (n_periods == '0) ? NW'(1) : n_periods;
          to_d    = timeout_cyc;
          wd_d    = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (rise) begin
          cnt_t_d = CW'(1);
          cnt_h_d = CW'(1);
          per_d   = '0;
          wd_d    = '0;
          state_d = StGate;
        end else if (wd_exp) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      StGate: begin
        if (rise && last) begin
          out_t_d = cnt_t_q;
          out_h_d = cnt_h_q;
          valid_d = 1'b1;
          state_d = StIdle;
`ifdef DUTY_CONTINUOUS_EN
          // Terminating rise doubles as the opening rise of the next window.
          if (cont) begin
            state_d = StGate;
            cnt_t_d = CW'(1);
            cnt_h_d = CW'(1);
            per_d   = '0;
            wd_d    = '0;
          end
`endif
        end else if (rise) begin
          per_d   = per_q + NW'(1);
          cnt_t_d = sat_inc(cnt_t_q, 1'b1);
          cnt_h_d = sat_inc(cnt_h_q, 1'b1);
          wd_d    = '0;
        end else if (wd_exp) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_t_d = sat_inc(cnt_t_q, 1'b1);
          cnt_h_d = sat_inc(cnt_h_q, s2_q);
          wd_d    = wd_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_t_q <= '0;
      cnt_h_q <= '0;
      wd_q    <= '0;
      to_q    <= '0;
      per_q   <= '0;
      n_q     <= '0;
      out_t_q <= '0;
      out_h_q <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sig;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      cnt_t_q <= cnt_t_d;
      cnt_h_q <= cnt_h_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      per_q   <= per_d;
      n_q     <= n_d;
      out_t_q <= out_t_d;
      out_h_q <= out_h_d;
      valid_q <= valid_d;
      terr_q  <= terr_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign valid       = valid_q;
  assign timeout_err = terr_q;
  assign out_T       = out_t_q;
  assign out_high    = out_h_q;

endmodule

// File: tb/tb_duty_meas_ctrl.sv
// Bench for duty_meas_ctrl: timestamp-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_duty_meas_ctrl;

  localparam int unsigned CW = 32;
  localparam int unsigned NW = 8;

  logic          clk = 1'b0;
  logic          rst, start, sig;
  logic [NW-1:0] n_periods;
  logic [CW-1:0] timeout_cyc;
  logic          busy, valid, timeout_err;
  logic [CW-1:0] out_high, out_T;
`ifdef DUTY_CONTINUOUS_EN
  logic          cont = 1'b0;
`endif

  duty_meas_ctrl #(.CW(CW), .NW(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n_periods   (n_periods),
    .timeout_cyc (timeout_cyc),
    .sig         (sig),
`ifdef DUTY_CONTINUOUS_EN
    .cont        (cont),
`endif
    .busy        (busy),
    .valid       (valid),
    .out_high    (out_high),
    .out_T       (out_T),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Stimulus waveform for sig: 0 = low, 1 = high, 2 = periodic (per_c cycles, hi_c high).
  int sig_mode = 0;
  int per_c = 10, hi_c = 3, ph = 0;
  initial begin
    sig = 1'b0;
    forever begin
      @(negedge clk);
      case (sig_mode)
        0: sig = 1'b0;
        1: sig = 1'b1;
        default: begin
          sig = (ph < hi_c);
          ph  = (ph + 1 >= per_c) ? 0 : ph + 1;
        end
      endcase
    end
  end

  // Reference model: works in absolute cycle stamps (window open time, last watchdog restart).
  logic          model_ok = 1'b0;
  logic          exp_valid = 1'b0, exp_terr = 1'b0, exp_busy = 1'b0;
  logic [CW-1:0] exp_T = '0, exp_H = '0;
  initial begin
    int unsigned t, mn, mto, mref, mfirst, mhi, mrises;
    int   phase;
    logic [2:0] h;
    logic rise_m, lvl, expired;
    t = 0; phase = 0; h = '0; mn = 1; mto = 0; mref = 0; mfirst = 0; mhi = 0; mrises = 0;
    forever begin
      @(posedge clk);
      rise_m    = h[1] & ~h[2];
      lvl       = h[1];
      expired   = (mto != 0) && ((t - mref) == mto - 1) && !rise_m;
      exp_valid = 1'b0;
      exp_terr  = 1'b0;
      if (rst) begin
        phase = 0; exp_T = '0; exp_H = '0; h = '0; model_ok = 1'b1;
      end else begin
        case (phase)
          0: if (start) begin
            mn = (n_periods == 0) ? 1 : int'(n_periods);
            mto = timeout_cyc; mref = t + 1; phase = 1;
          end
          1: if (rise_m) begin
            mfirst = t; mhi = 1; mrises = 0; mref = t + 1; phase = 2;
          end else if (expired) begin
            exp_terr = 1'b1; phase = 0;
          end
          default: if (rise_m) begin
            mrises++;
            if (mrises == mn) begin
              exp_valid = 1'b1; exp_T = CW'(t - mfirst); exp_H = CW'(mhi); phase = 0;
`ifdef DUTY_CONTINUOUS_EN
              if (cont) begin
                mfirst = t; mhi = 1; mrises = 0; mref = t + 1; phase = 2;
              end
`endif
            end else begin
              mhi++; mref = t + 1;
            end
          end else if (expired) begin
            exp_terr = 1'b1; phase = 0;
          end else begin
            mhi += lvl;
          end
        endcase
        h = {h[1:0], sig};
      end
      exp_busy = (phase != 0);
      t++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("cyc_valid", valid, exp_valid);
        chk("cyc_timeout_err", timeout_err, exp_terr);
        chk("cyc_busy", busy, exp_busy);
        chk("cyc_out_T", out_T, exp_T);
        chk("cyc_out_high", out_high, exp_H);
      end
    end
  end

  task automatic set_periodic(input int p, input int hh);
    per_c = p; hi_c = hh; ph = 0; sig_mode = 2;
    repeat (3 * p + 5) @(negedge clk);
  endtask

  // mid: 0 plain, 1 second start mid-gate, 2 reset mid-gate
  task automatic run_meas(input string name, input int n, input int mid,
                          input int et, input int eh);
    int got, vseen;
    n_periods = NW'(n); timeout_cyc = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0; vseen = 0;
    for (int k = 0; k < 2000; k++) begin
      if (valid) begin got = 1; break; end
      if (k == 20 && mid == 1) start = 1'b1;
      if (k == 21) start = 1'b0;
      if (k == 20 && mid == 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({name, "_rst_busy"}, busy, 0);
        chk({name, "_rst_T"}, out_T, 0);
        chk({name, "_rst_H"}, out_high, 0);
        for (int j = 0; j < 60; j++) begin
          @(negedge clk);
          if (valid) vseen++;
        end
        chk({name, "_rst_no_valid"}, vseen, 0);
        return;
      end
      @(negedge clk);
    end
    chk({name, "_done"}, got, 1);
    if (got == 1) begin
      chk({name, "_T"}, out_T, et);
      chk({name, "_H"}, out_high, eh);
      chk({name, "_busy_low"}, busy, 0);
    end
    @(negedge clk);
  endtask

  task automatic run_timeout(input string name, input int lvl, input int et, input int eh);
    int found, vseen;
    sig_mode = lvl;
    repeat (10) @(negedge clk);
    n_periods = NW'(1); timeout_cyc = CW'(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0; vseen = 0;
    for (int k = 1; k <= 120; k++) begin
      if (timeout_err && found == 0) found = k;
      if (valid) vseen++;
      @(negedge clk);
    end
    // Negedge k follows edge (k-1) after the ARM entry edge.
    chk({name, "_latency"}, found, 51);
    chk({name, "_no_valid"}, vseen, 0);
    chk({name, "_T_kept"}, out_T, et);
    chk({name, "_H_kept"}, out_high, eh);
    timeout_cyc = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_periods = '0; timeout_cyc = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_terr", timeout_err, 0);
    chk("reset_T", out_T, 0);
    chk("reset_H", out_high, 0);
    rst = 1'b0;

    set_periodic(10, 3);
    run_meas("p10_n1", 1, 0, 10, 3);
    run_meas("p10_n4", 4, 0, 40, 12);
    run_meas("p10_n0", 0, 0, 10, 3);
    run_timeout("to_low", 0, 10, 3);
    run_timeout("to_high", 1, 10, 3);
    set_periodic(7, 1);
    run_meas("pulse7_n2", 2, 0, 14, 2);
    set_periodic(10, 3);
    run_meas("mid_start", 4, 1, 40, 12);
    run_meas("mid_rst", 4, 2, 0, 0);

`ifdef DUTY_CONTINUOUS_EN
    begin
      int gap, got;
      set_periodic(10, 5);
      cont = 1'b1; n_periods = NW'(1); timeout_cyc = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 5; w++) begin
        gap = 0; got = 0;
        for (int k = 1; k <= 200; k++) begin
          @(negedge clk);
          if (valid) begin gap = k; got = 1; break; end
        end
        chk("cont_window", got, 1);
        chk("cont_T", out_T, 10);
        chk("cont_H", out_high, 5);
        if (w >= 1 && w <= 3) chk("cont_gap", gap, 10);
        if (w <= 2) chk("cont_busy_held", busy, 1);
        if (w == 4) chk("cont_end_busy", busy, 0);
        if (w == 3) cont = 1'b0;
      end
      chk("cont_dropped_idle", busy, 0);
    end
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/duty_meas_ctrl.md
Name: duty_meas_ctrl

Overview:
- Sequencer for the duty-cycle/period measurement path.
- On a start request it synchronizes the external `sig`, aligns the measurement gate to a rising edge of `sig`, and counts total and high `clk` cycles over N whole periods.
- It then latches the results and reports them with a one-cycle valid strobe.
- A watchdog aborts the measurement when `sig` stalls (stuck high, stuck low, or absent). The block sits between the control/register interface and the measurement outputs.

Parameters:
- CW, 32, width of the cycle counters, `out_high`, `out_T` and `timeout_cyc`.
- NW, 8, width of `n_periods` and of the internal period counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement; ignored while `busy`.
- n_periods  in  NW  number of `sig` periods to integrate; sampled at accepted start; 0 is treated as 1.
- timeout_cyc  in  CW  watchdog limit in `clk` cycles; sampled at accepted start; 0 disables the watchdog.
- sig  in  1  asynchronous signal under measurement.
- busy  out  1  high whenever the FSM is not in IDLE.
- valid  out  1  one-cycle pulse; `out_high`/`out_T` updated in the same cycle.
- out_high  out  CW  `clk` cycles `sig` was high over the gate.
- out_T  out  CW  `clk` cycles of the gate (N periods).
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Sync and edge detect:
  - `sig` passes through 2 flops giving s1 and s2. A third flop s3 follows s2.
  - rise = s2 & ~s3. Sampled level = s2.
- Reset: state=IDLE. busy, valid, timeout_err = 0. out_high, out_T = 0. All internal counters and sync flops = 0.
- States: IDLE, ARM, GATE.
- IDLE:
  - start=1 latches N (max(n_periods,1)) and timeout_cyc, clears wd to 0, goes to ARM.
  - valid and timeout_err are 0 in every cycle not explicitly pulsing.
- ARM (wait for the first rise):
  - On rise: cnt_T<=1, cnt_H<=1, per<=0, wd<=0, go to GATE. The rise cycle is counted.
  - Otherwise wd increments.
- GATE, per clk:
  - If rise and per+1==N: out_T<=cnt_T, out_high<=cnt_H, valid<=1 on the next edge, go to IDLE. The terminating rise cycle is not counted.
  - If rise and per+1<N: per++, cnt_T++, cnt_H++, wd<=0.
  - Otherwise: cnt_T++, cnt_H += s2, wd++.
- Result identity: periodic `sig` with period P and high time H (in clk cycles) gives out_T=N*P, out_high=N*H. Latency from the terminating rise detect to valid is 1 cycle.
- Watchdog:
  - In ARM or GATE, if timeout_cyc!=0 and wd==timeout_cyc-1 with no rise that cycle: timeout_err pulses 1 cycle and the FSM goes to IDLE.
  - out_high/out_T keep their old values and valid stays 0.
- Saturation: cnt_T and cnt_H saturate at all-ones; they never wrap.
- Simultaneous events:
  - start while busy is ignored.
  - If a rise and watchdog expiry occur in the same cycle, the rise wins.
  - valid and timeout_err are never high together.
- rst asserted mid-measurement returns everything to reset values on the next edge. No valid is produced.
- out_high/out_T hold their values until the next valid.

Optional Feature:
- Macro: DUTY_CONTINUOUS_EN.
- Enabled:
  - Adds input port `cont` (1 bit).
  - When the GATE terminates with cont=1, the FSM stays in GATE instead of going to IDLE.
  - It reuses the terminating rise as the first rise of the next window: cnt_T<=1, cnt_H<=1, per<=0, wd<=0.
  - busy stays 1 and valid pulses once per window with no lost period.
  - cont=0 at termination returns to IDLE.
- Disabled: no `cont` port; strictly single-shot as described above.

Test Plan:
- sig period 10 clk, high 3, n_periods=1, timeout_cyc=0, pulse start -> one valid pulse; out_T=10, out_high=3; busy falls in the valid cycle.
- Same sig, n_periods=4 -> out_T=40, out_high=12. n_periods=0 -> out_T=10, out_high=3.
- sig held 0, timeout_cyc=50, start -> timeout_err pulses exactly 50 cycles after entering ARM; valid never asserts; outputs unchanged. Repeat with sig held 1 -> same result.
- start pulsed again mid-GATE and rst asserted mid-GATE (separate runs):
  - First run: the second start has no effect and the result is unchanged.
  - Second run: busy=0 and out_T=out_high=0 on the next cycle; no valid.
- sig with 100% low except a 1-cycle high every 7 clk, n_periods=2 -> out_T=14, out_high=2.
- DUTY_CONTINUOUS_EN, cont=1, period 10/high 5, n_periods=1 -> valid every 10 cycles with out_T=10, out_high=5; dropping cont ends after the current window.
